// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with a shared memory port.
// Sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       OPCode,
    input  logic [5:0]       FunctCode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCsrc,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUsrc,
    output logic [3:0]       ALUop,
    output logic [1:0]       EXTop,
    output logic             instr_done,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nx;

    logic rtype;
    logic is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;

    assign rtype   = (OPCode == 6'h00);
    assign is_addu = rtype && (FunctCode == 6'h21);
    assign is_subu = rtype && (FunctCode == 6'h23);
    assign is_jr   = rtype && (FunctCode == 6'h08);
    assign is_ori  = (OPCode == 6'h0D);
    assign is_lui  = (OPCode == 6'h0F);
    assign is_lw   = (OPCode == 6'h23);
    assign is_sw   = (OPCode == 6'h2B);
    assign is_beq  = (OPCode == 6'h04);
    assign is_jal  = (OPCode == 6'h03);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            retire_cnt <= '0;
        end else begin
            state <= state_nx;
            if (instr_done)
                retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_sel    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCsrc      = 2'd0;
        RegWrite   = 1'b0;
        RegDst     = 2'd0;
        MemtoReg   = 2'd0;
        ALUsrc     = 2'd0;
        ALUop      = 4'd0;
        EXTop      = 2'd0;
        instr_done = 1'b0;
        // Outputs are forced low for the whole time reset is held.
        if (reset_n) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        IRWrite  = 1'b1;
                        PCWrite  = 1'b1;
                        state_nx = DECODE;
                    end
                end
                DECODE: begin
                    if (is_addu || is_subu || is_ori || is_lui ||
                        is_lw || is_sw || is_beq) begin
                        state_nx = EXEC;
                    end else if (is_jal) begin
                        state_nx = WB;
                    end else begin
                        if (is_jr) begin
                            PCWrite = 1'b1;
                            PCsrc   = 2'd3;
                        end
                        instr_done = 1'b1;
                        state_nx   = FETCH;
                    end
                end
                EXEC: begin
                    state_nx = WB;
                    if (is_subu) begin
                        ALUop = 4'd1;
                    end else if (is_ori) begin
                        ALUop  = 4'd2;
                        ALUsrc = 2'd1;
                    end else if (is_lui) begin
                        ALUop  = 4'd2;
                        ALUsrc = 2'd1;
                        EXTop  = 2'd2;
                    end else if (is_lw || is_sw) begin
                        ALUsrc   = 2'd1;
                        EXTop    = 2'd1;
                        state_nx = MEM;
                    end else if (is_beq) begin
                        ALUop      = 4'd1;
                        EXTop      = 2'd1;
                        PCsrc      = 2'd1;
                        PCWrite    = zero;
                        instr_done = 1'b1;
                        state_nx   = FETCH;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    mem_sel  = 1'b1;
                    MemWrite = is_sw;
                    if (mem_ack) begin
                        if (is_lw) begin
                            state_nx = WB;
                        end else begin
                            instr_done = 1'b1;
                            state_nx   = FETCH;
                        end
                    end
                end
                WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = FETCH;
                    if (is_addu || is_subu) begin
                        RegDst = 2'd1;
                    end else if (is_lw) begin
                        MemtoReg = 2'd1;
                    end else if (is_jal) begin
                        RegDst   = 2'd2;
                        MemtoReg = 2'd2;
                        PCWrite  = 1'b1;
                        PCsrc    = 2'd2;
                    end
                end
                default: begin
                    state_nx = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed cycle-by-cycle checks of the mc_ctrl control FSM.
// Expected output vectors are hand-computed per instruction and cycle.
module tb_mc_ctrl;

    logic        clk;
    logic        reset_n;
    logic [5:0]  OPCode;
    logic [5:0]  FunctCode;
    logic        zero;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_sel;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCsrc;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [1:0]  ALUsrc;
    logic [3:0]  ALUop;
    logic [1:0]  EXTop;
    logic        instr_done;
    logic [31:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .OPCode     (OPCode),
        .FunctCode  (FunctCode),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_sel    (mem_sel),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCsrc      (PCsrc),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUsrc     (ALUsrc),
        .ALUop      (ALUop),
        .EXTop      (EXTop),
        .instr_done (instr_done),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] outs;
    assign outs = {mem_req, mem_sel, MemWrite, IRWrite, PCWrite, PCsrc,
                   RegWrite, RegDst, MemtoReg, ALUsrc, ALUop, EXTop,
                   instr_done};

    // Field order: req sel mw irw pcw pcsrc rw rdst m2r asrc aop ext done
    function automatic logic [20:0] pk(
        input logic       req, input logic       sel,
        input logic       mw,  input logic       irw,
        input logic       pcw, input logic [1:0] pcs,
        input logic       rw,  input logic [1:0] rd,
        input logic [1:0] m2r, input logic [1:0] asrc,
        input logic [3:0] aop, input logic [1:0] ext,
        input logic       done);
        return {req, sel, mw, irw, pcw, pcs, rw, rd, m2r,
                asrc, aop, ext, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full output bundle mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [20:0] exp);
        @(negedge clk);
        chk(tag, {11'd0, outs}, {11'd0, exp});
        @(posedge clk);
        #1;
    endtask

    logic [20:0] fetch_ack;
    logic [20:0] idle;
    logic [20:0] mem_wait;

    initial begin
        fetch_ack = pk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle      = '0;
        reset_n   = 1'b0;
        mem_ack   = 1'b1;
        OPCode    = 6'h00;
        FunctCode = 6'h00;
        zero      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outs", {11'd0, outs}, 32'd0);
            chk("rst_cnt", retire_cnt, 32'd0);
            @(posedge clk);
        end
        #1;
        reset_n = 1'b1;

        // addu: 4 cycles
        OPCode = 6'h00; FunctCode = 6'h21;
        step("addu_f", fetch_ack);
        step("addu_d", idle);
        step("addu_e", idle);
        step("addu_w", pk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        chk("addu_cnt", retire_cnt, 32'd1);

        // lw with 2 wait cycles in MEM: 7 cycles
        OPCode = 6'h23; FunctCode = 6'h00;
        step("lw_f", fetch_ack);
        step("lw_d", idle);
        step("lw_e", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        mem_ack = 1'b0;
        mem_wait = pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lw_m1", mem_wait);
        step("lw_m2", mem_wait);
        mem_ack = 1'b1;
        step("lw_m3", mem_wait);
        step("lw_w", pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        chk("lw_cnt", retire_cnt, 32'd2);

        // beq taken: 3 cycles
        OPCode = 6'h04; zero = 1'b1;
        step("beq1_f", fetch_ack);
        step("beq1_d", idle);
        step("beq1_e", pk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1));
        chk("beq1_cnt", retire_cnt, 32'd3);

        // beq not taken: no PC write
        zero = 1'b0;
        step("beq0_f", fetch_ack);
        step("beq0_d", idle);
        @(negedge clk);
        chk("beq0_pcw", {31'd0, PCWrite}, 32'd0);
        chk("beq0_done", {31'd0, instr_done}, 32'd1);
        chk("beq0_aop", {28'd0, ALUop}, 32'd1);
        @(posedge clk);
        #1;
        chk("beq0_cnt", retire_cnt, 32'd4);

        // jal: 3 cycles
        OPCode = 6'h03;
        step("jal_f", fetch_ack);
        step("jal_d", idle);
        step("jal_w", pk(0, 0, 0, 0, 1, 2, 1, 2, 2, 0, 0, 0, 1));

        // jr: 2 cycles
        OPCode = 6'h00; FunctCode = 6'h08;
        step("jr_f", fetch_ack);
        step("jr_d", pk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1));
        chk("jaljr_cnt", retire_cnt, 32'd6);

        // sw, reset pulsed during a MEM wait cycle
        OPCode = 6'h2B; FunctCode = 6'h00;
        step("sw_f", fetch_ack);
        step("sw_d", idle);
        step("sw_e", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        mem_ack = 1'b0;
        step("sw_m1", pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("sw_m2_mw", {31'd0, MemWrite}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("sw_rst_mw", {31'd0, MemWrite}, 32'd0);
        chk("sw_rst_outs", {11'd0, outs}, 32'd0);
        chk("sw_rst_cnt", retire_cnt, 32'd0);
        @(posedge clk);
        #1;
        chk("sw_rst_hold", {11'd0, outs}, 32'd0);
        reset_n = 1'b1;
        mem_ack = 1'b1;

        // unknown opcode after reset: restarts in FETCH, 2 cycles
        OPCode = 6'h3F;
        step("unk_f", fetch_ack);
        step("unk_d", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("unk_cnt", retire_cnt, 32'd1);

        // nop back-to-back
        OPCode = 6'h00; FunctCode = 6'h00;
        step("nop_f", fetch_ack);
        step("nop_d", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("nop_cnt", retire_cnt, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS core. It decodes the instruction set addu, subu, ori, lw, sw, beq, lui, jal, jr and nop, and sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. It also owns the single shared memory port, issuing instruction and data requests through a req/ack handshake. It drives every datapath select and write enable, and it counts retired instructions for verification.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- OPCode  in  6  IR[31:26]; valid from DECODE onward
- FunctCode  in  6  IR[5:0]; valid from DECODE onward
- zero  in  1  ALU equal flag, sampled in EXEC of beq
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALUOut)
- MemWrite  out  1  write strobe, qualified by mem_req
- IRWrite  out  1  load IR with memory read data
- PCWrite  out  1  load PC
- PCsrc  out  2  0 = PC+4, 1 = branch target, 2 = {PC[31:28],imm26,2'b00}, 3 = GPR[rs]
- RegWrite  out  1  GPR write
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31
- MemtoReg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- ALUsrc  out  2  0 = GPR[rt], 1 = extended imm
- ALUop  out  4  0 = add, 1 = sub, 2 = or
- EXTop  out  2  0 = zero-ext, 1 = sign-ext, 2 = imm<<16
- instr_done  out  1  one-cycle pulse on retire
- retire_cnt  out  CNT_W  retired instruction count

## Operation
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4). All outputs are decoded combinationally from the state and the OPCode/FunctCode inputs.
- Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, mem_sel=0.
  - Hold until mem_ack=1. In the ack cycle: IRWrite=1, PCWrite=1, PCsrc=0, then go to DECODE.
- DECODE, by instruction class:
  - addu, subu, ori, lui, lw, sw, beq: go to EXEC.
  - jal: go to WB.
  - jr: PCWrite=1, PCsrc=3, retire, go to FETCH.
  - Anything else (nop, unknown opcode or funct): no writes, retire, go to FETCH.
- EXEC:
  - addu: ALUop=0, ALUsrc=0, go to WB.
  - subu: ALUop=1, ALUsrc=0, go to WB.
  - ori: ALUop=2, ALUsrc=1, EXTop=0, go to WB.
  - lui: ALUop=2, ALUsrc=1, EXTop=2, go to WB.
  - lw/sw: ALUop=0, ALUsrc=1, EXTop=1, go to MEM.
  - beq: ALUop=1, ALUsrc=0, EXTop=1, PCsrc=1, PCWrite=zero. Retire, go to FETCH.
- MEM:
  - mem_req=1, mem_sel=1, MemWrite=sw.
  - Hold until mem_ack=1.
  - On ack, lw goes to WB (MDR loads externally); sw retires and goes to FETCH.
- WB, then retire and go to FETCH:
  - addu/subu: RegWrite=1, RegDst=1, MemtoReg=0.
  - ori/lui: RegWrite=1, RegDst=0, MemtoReg=0.
  - lw: RegWrite=1, RegDst=0, MemtoReg=1.
  - jal: RegWrite=1, RegDst=2, MemtoReg=2, PCWrite=1, PCsrc=2. PC already holds jal+4.
- Retire:
  - instr_done=1 in the final cycle of each instruction.
  - retire_cnt increments by 1 at the following edge and wraps modulo 2^CNT_W without saturating.
- Handshake:
  - mem_req stays high until the ack cycle.
  - mem_sel and MemWrite are stable while mem_req=1.
  - mem_ack outside FETCH/MEM is ignored.
  - Ack latency is unbounded, with no timeout.

## Timing
- Reset: reset_n low immediately forces state=FETCH and retire_cnt=0.
- While reset_n=0, every output is 0, including mem_req, PCWrite and RegWrite.
- The first mem_req appears in the cycle after the reset_n rise.
- Cycle counts with zero-wait ack (ack in the first request cycle):
  - addu, subu, ori, lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - jal: 3 cycles.
  - jr and nop: 2 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-MEM of sw drops MemWrite in the same cycle (asynchronous), and no write completes.
- Back-to-back instructions: FETCH follows the retire cycle directly, with no bubble.

## Test plan
- Reset held for 3 cycles with mem_ack=1 -> all outputs 0, retire_cnt=0. The cycle after release shows mem_req=1, mem_sel=0.
- addu (OP=0, F=0x21), ack every cycle -> RegWrite=1, RegDst=1 in cycle 4. instr_done in cycle 4, retire_cnt=1.
- lw (OP=0x23) with ack delayed 2 cycles in MEM -> MEM held 3 cycles with mem_sel=1, MemWrite=0. Then WB with MemtoReg=1, RegDst=0. Total 7 cycles.
- beq (OP=0x04), run twice with zero=1 then zero=0 -> PCWrite=1, PCsrc=1 only on the zero=1 run. Each run is 3 cycles.
- jal (OP=0x03) then jr (OP=0, F=0x08) -> jal WB shows RegDst=2, MemtoReg=2, PCsrc=2. jr DECODE shows PCsrc=3. retire_cnt +2.
- sw (OP=0x2B) with reset_n pulsed low during a MEM wait cycle -> MemWrite falls immediately, state=FETCH, retire_cnt=0. OP=0x3F then retires in 2 cycles with no writes.
